// File: rtl/image_stream_pkg.sv
// rtl/image_stream_pkg.sv - shared types and sizing helpers for the image stream source
//
// Purpose : state encoding, pixel type and sizing functions used by
//           image_stream_source and pixel_frame_buffer.
// Contents: stream_state_e, pixel_t, npix(), ptr_w()
package image_stream_pkg;

   parameter int PixBits = 4;

   typedef logic [PixBits-1:0] pixel_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } stream_state_e;

   // Pixels in one square frame plane.
   function automatic int npix(input int width);
      return width * width;
   endfunction

   // Address width for a buffer of the given depth, never narrower than one bit.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/pixel_frame_buffer.sv
// rtl/pixel_frame_buffer.sv - frame RAM with synchronous write and asynchronous read
//
// Purpose : holds one frame of all channel planes, one word per pixel.
// Ports   : clk_i     - clock
//           we_i      - write strobe
//           waddr_i   - write pixel index
//           wdata_i   - write word (all channels)
//           raddr_i   - read pixel index
//           rdata_o   - read word, combinational from raddr_i
// Contents are not reset.
module pixel_frame_buffer #(
   parameter int Depth = 64,
   parameter int Width = 4,
   parameter int AddrW = 6
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AddrW-1:0] waddr_i,
   input  logic [Width-1:0] wdata_i,
   input  logic [AddrW-1:0] raddr_i,
   output logic [Width-1:0] rdata_o
);

   logic [Width-1:0] mem_q [Depth];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/image_stream_source.sv
// rtl/image_stream_source.sv - buffered raster-order pixel source with ready/valid output
//
// Purpose : streams num_frames copies of a buffered frame, each followed by a
//           drain window of DrainCycles ready cycles with valid low.
// Ports   : clk, res_n (sync, active low)
//           load_en/load_addr/load_data - buffer write, honoured only when idle
//           start/num_frames            - run request, num_frames 0 means 1
//           out_ready/out_valid/out_data/out_last - pixel stream
//           busy, frame_done            - run status
//           checksum (IMAGE_STREAM_SOURCE_CHECKSUM_EN only) - sum of channel 0
//                                         over transferred beats
// Option  : IMAGE_STREAM_SOURCE_CHECKSUM_EN adds the checksum port and adder.
module image_stream_source
   import image_stream_pkg::*;
#(
   parameter int BitSize     = 4,
   parameter int ImageWidth  = 8,
   parameter int Channels    = 1,
   parameter int DrainCycles = 448,
   parameter int MaxFrames   = 16,
   localparam int NPix  = npix(ImageWidth),
   localparam int PW    = ptr_w(NPix),
   localparam int FW    = $clog2(MaxFrames + 1),
   localparam int DataW = Channels * BitSize,
   localparam int CsW   = BitSize + $clog2(NPix) + FW
) (
   input  logic                              clk,
   input  logic                              res_n,
   input  logic                              load_en,
   input  logic [PW-1:0]                     load_addr,
   input  logic [DataW-1:0]                  load_data,
   input  logic                              start,
   input  logic [FW-1:0]                     num_frames,
   input  logic                              out_ready,
   output logic                              out_valid,
   output logic [Channels-1:0][BitSize-1:0]  out_data,
   output logic                              out_last,
   output logic                              busy,
   output logic                              frame_done
`ifdef IMAGE_STREAM_SOURCE_CHECKSUM_EN
   ,
   output logic [CsW-1:0]                    checksum
`endif
);

   localparam int DW = (DrainCycles > 1) ? $clog2(DrainCycles) : 1;
   localparam logic [PW-1:0] LastPix   = PW'(NPix - 1);
   localparam logic [DW-1:0] DrainLast = (DrainCycles > 0) ? DW'(DrainCycles - 1) : '0;

   stream_state_e    state_q, state_d;
   logic [PW-1:0]    pix_ptr_q, pix_ptr_d;
   logic [FW-1:0]    frame_cnt_q, frame_cnt_d;
   logic [FW-1:0]    frames_q, frames_d;
   logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
   logic             first_q, first_d;
   logic [DataW-1:0] pix0_q, pix0_d;

   logic [PW-1:0]    rd_addr;
   logic [DataW-1:0] rd_data;
   logic             buf_we;
   logic             xfer;
   logic             frame_end;

   // The read port idles on pixel 0 so the start cycle can snapshot it.
   assign rd_addr = (state_q == IDLE) ? '0 : pix_ptr_q;
   assign buf_we  = load_en && (state_q == IDLE);

   pixel_frame_buffer #(
      .Depth (NPix),
      .Width (DataW),
      .AddrW (PW)
   ) u_buf (
      .clk_i   (clk),
      .we_i    (buf_we),
      .waddr_i (load_addr),
      .wdata_i (load_data),
      .raddr_i (rd_addr),
      .rdata_o (rd_data)
   );

   always_ff @(posedge clk) begin
      if (!res_n) begin
         state_q     <= IDLE;
         pix_ptr_q   <= '0;
         frame_cnt_q <= '0;
         frames_q    <= '0;
         drain_cnt_q <= '0;
         first_q     <= 1'b0;
         pix0_q      <= '0;
      end else begin
         state_q     <= state_d;
         pix_ptr_q   <= pix_ptr_d;
         frame_cnt_q <= frame_cnt_d;
         frames_q    <= frames_d;
         drain_cnt_q <= drain_cnt_d;
         first_q     <= first_d;
         pix0_q      <= pix0_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pix_ptr_d   = pix_ptr_q;
      frame_cnt_d = frame_cnt_q;
      frames_d    = frames_q;
      drain_cnt_d = drain_cnt_q;
      first_d     = first_q;
      pix0_d      = pix0_q;
      out_valid   = 1'b0;
      out_last    = 1'b0;
      out_data    = '0;
      frame_done  = 1'b0;
      frame_end   = 1'b0;
      busy        = (state_q != IDLE);
      xfer        = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               frames_d    = (num_frames == '0) ? FW'(1) : num_frames;
               pix_ptr_d   = '0;
               frame_cnt_d = '0;
               drain_cnt_d = '0;
               // Pixel 0 is captured before a same-cycle load can overwrite
               // it, so the first beat of the run shows the old value.
               first_d     = 1'b1;
               pix0_d      = rd_data;
               state_d     = STREAM;
            end
         end
         STREAM: begin
            out_valid = 1'b1;
            out_last  = (pix_ptr_q == LastPix);
            out_data  = first_q ? pix0_q : rd_data;
            xfer      = out_ready;
            if (out_ready) begin
               first_d   = 1'b0;
               pix_ptr_d = pix_ptr_q + PW'(1);
               if (out_last) begin
                  pix_ptr_d = '0;
                  if (DrainCycles == 0) begin
                     frame_end = 1'b1;
                  end else begin
                     drain_cnt_d = '0;
                     state_d     = DRAIN;
                  end
               end
            end
         end
         DRAIN: begin
            if (out_ready) begin
               if (drain_cnt_q == DrainLast) begin
                  frame_end = 1'b1;
               end else begin
                  drain_cnt_d = drain_cnt_q + DW'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (frame_end) begin
         frame_done  = 1'b1;
         frame_cnt_d = frame_cnt_q + FW'(1);
         pix_ptr_d   = '0;
         state_d     = ((frame_cnt_q + FW'(1)) == frames_q) ? IDLE : STREAM;
      end
   end

`ifdef IMAGE_STREAM_SOURCE_CHECKSUM_EN
   logic [CsW-1:0] checksum_q;

   always_ff @(posedge clk) begin
      if (!res_n) begin
         checksum_q <= '0;
      end else if ((state_q == IDLE) && start) begin
         checksum_q <= '0;
      end else if (xfer) begin
         checksum_q <= checksum_q + CsW'(out_data[0]);
      end
   end

   assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_image_stream_source.sv
// tb/tb_image_stream_source.sv - scoreboard bench for image_stream_source
module tb_image_stream_source;

   logic       clk = 1'b0;
   logic       res_n;
   logic       load_en, load_en0;
   logic [5:0] load_addr;
   logic [3:0] load_data;
   logic       start, start0;
   logic [4:0] num_frames;
   logic       out_ready;

   logic            out_valid, out_last, busy, frame_done;
   logic [0:0][3:0] out_data;
   logic            out_valid_z, out_last_z, busy_z, frame_done_z;
   logic [0:0][3:0] out_data_z;
`ifdef IMAGE_STREAM_SOURCE_CHECKSUM_EN
   logic [14:0]     checksum, checksum_z;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   logic [3:0] model [64];
   logic [4:0] exp_q[$];
   logic [4:0] exp0_q[$];

   logic       stall_q = 1'b0;
   logic [3:0] hold_q  = '0;

   always #5 clk = ~clk;

   image_stream_source u_dut (
      .clk        (clk),
      .res_n      (res_n),
      .load_en    (load_en),
      .load_addr  (load_addr),
      .load_data  (load_data),
      .start      (start),
      .num_frames (num_frames),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_last   (out_last),
      .busy       (busy),
      .frame_done (frame_done)
`ifdef IMAGE_STREAM_SOURCE_CHECKSUM_EN
      ,
      .checksum   (checksum)
`endif
   );

   image_stream_source #(.DrainCycles(0)) u_dut0 (
      .clk        (clk),
      .res_n      (res_n),
      .load_en    (load_en0),
      .load_addr  (load_addr),
      .load_data  (load_data),
      .start      (start0),
      .num_frames (num_frames),
      .out_ready  (out_ready),
      .out_valid  (out_valid_z),
      .out_data   (out_data_z),
      .out_last   (out_last_z),
      .busy       (busy_z),
      .frame_done (frame_done_z)
`ifdef IMAGE_STREAM_SOURCE_CHECKSUM_EN
      ,
      .checksum   (checksum_z)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Scoreboard: every transferred beat must match the next queued pixel.
   always @(negedge clk) begin
      logic [4:0] e;
      if (stall_q) begin
         check("hold_stable", {27'd0, out_valid, out_data}, {27'd0, 1'b1, hold_q});
      end
      stall_q <= res_n && out_valid && !out_ready;
      hold_q  <= out_data;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("extra_beat", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("beat", {27'd0, out_last, out_data}, {27'd0, e});
         end
      end
      if (out_valid_z && out_ready) begin
         if (exp0_q.size() == 0) begin
            check("extra_beat_z", 32'd1, 32'd0);
         end else begin
            e = exp0_q.pop_front();
            check("beat_z", {27'd0, out_last_z, out_data_z}, {27'd0, e});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // mode[0]: ready toggles 1,0,1,0  mode[1]: mid-run start and load
   // mode[2]: load pixel 0 = 9 in the same cycle as start
   task automatic run(input bit sel, input int nf, input int mode, input int exp_frames,
                      input int exp_last_fd, input int exp_vlow);
      int cyc, fd, last_fd, vlow;
      bit done;
      logic [3:0] old0, d;
      old0 = model[0];
      if (mode[2]) model[0] = 4'h9;
      for (int f = 0; f < exp_frames; f++) begin
         for (int p = 0; p < 64; p++) begin
            d = (mode[2] && f == 0 && p == 0) ? old0 : model[p];
            if (sel) exp0_q.push_back({p == 63, d});
            else     exp_q.push_back({p == 63, d});
         end
      end
      tick();
      num_frames = nf[4:0];
      if (sel) start0 = 1'b1; else start = 1'b1;
      if (mode[2]) begin
         load_en = 1'b1; load_addr = 6'd0; load_data = 4'h9;
      end
      tick();
      start = 1'b0; start0 = 1'b0; load_en = 1'b0;
      cyc = 1; fd = 0; last_fd = -1; vlow = 0; done = 1'b0;
      while (!done && cyc < 4000) begin
         out_ready = mode[0] ? cyc[0] : 1'b1;
         if (mode[1] && cyc == 10) begin
            if (sel) start0 = 1'b1; else start = 1'b1;
         end
         if (mode[1] && cyc == 20) begin
            load_addr = 6'd5; load_data = 4'hF;
            if (sel) load_en0 = 1'b1; else load_en = 1'b1;
         end
         @(negedge clk);
         if (sel ? frame_done_z : frame_done) begin
            fd++;
            last_fd = cyc;
         end
         if ((sel ? busy_z : busy) && !(sel ? out_valid_z : out_valid)) vlow++;
         if (!(sel ? busy_z : busy)) done = 1'b1;
         tick();
         start = 1'b0; start0 = 1'b0; load_en = 1'b0; load_en0 = 1'b0;
         cyc++;
      end
      check("run_done", {31'd0, done}, 32'd1);
      check("frame_done_cnt", fd, exp_frames);
      check("frame_done_cycle", last_fd, exp_last_fd);
      check("drain_cycles", vlow, exp_vlow);
      check("beats_left", sel ? exp0_q.size() : exp_q.size(), 32'd0);
      out_ready = 1'b1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_data"}, {28'd0, out_data}, 32'd0);
      check({tag, "_last"}, {31'd0, out_last}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_fdone"}, {31'd0, frame_done}, 32'd0);
   endtask

   initial begin
      res_n = 1'b0; load_en = 1'b0; load_en0 = 1'b0; load_addr = '0; load_data = '0;
      start = 1'b0; start0 = 1'b0; num_frames = 5'd1; out_ready = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      check_idle("reset");
      check("reset_busy_z", {31'd0, busy_z}, 32'd0);
      tick();
      res_n = 1'b1;

      for (int i = 0; i < 64; i++) begin
         load_en = 1'b1; load_en0 = 1'b1;
         load_addr = i[5:0]; load_data = i[3:0];
         model[i] = i[3:0];
         tick();
      end
      load_en = 1'b0; load_en0 = 1'b0;

      run(1'b0, 1, 0, 1, 512, 448);
      run(1'b0, 1, 1, 1, 1023, 896);
      run(1'b1, 3, 0, 3, 192, 0);
      run(1'b0, 0, 2, 1, 512, 448);

      // Abort after beat 29 has transferred, while beat 30 is on the bus.
      for (int p = 0; p < 30; p++) exp_q.push_back({1'b0, model[p]});
      num_frames = 5'd1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         out_ready = 1'b1;
         tick();
      end
      out_ready = 1'b0; res_n = 1'b0;
      tick();
      @(negedge clk);
      check_idle("abort");
      check("abort_beats_left", exp_q.size(), 32'd0);
      tick();
      res_n = 1'b1; out_ready = 1'b1;

      run(1'b0, 1, 0, 1, 512, 448);
      run(1'b0, 2, 4, 2, 1024, 896);

`ifdef IMAGE_STREAM_SOURCE_CHECKSUM_EN
      for (int i = 0; i < 64; i++) begin
         load_en = 1'b1; load_addr = i[5:0]; load_data = 4'b0111;
         model[i] = 4'b0111;
         tick();
      end
      load_en = 1'b0;
      run(1'b0, 2, 0, 2, 1024, 896);
      @(negedge clk);
      check("checksum", {17'd0, checksum}, 32'd896);
`endif

      repeat (4) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
